// File: rtl/conv_sequencer_pkg.sv
// Shared definitions for the convolution tile sequencer: state encoding,
// datapath command/status bit positions and the default address width.
package conv_sequencer_pkg;

    localparam int ADDR_W_DEF = 12;

    // dp_cmd bit positions
    localparam int CMD_GET_ADDR = 3;
    localparam int CMD_GET_DATA = 2;
    localparam int CMD_COUNT    = 1;
    localparam int CMD_WRITE    = 0;

    // dp_status bit positions
    localparam int ST_GOT_DATA  = 3;
    localparam int ST_READY     = 2;
    localparam int ST_CNT_DONE  = 1;
    localparam int ST_WRITTEN   = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_C,
        S_ADDR_W,
        S_DATA_C,
        S_DATA_W,
        S_CNT_C,
        S_CNT_W,
        S_WR_C,
        S_WR_W,
        S_NEXT,
        S_FIN
    } state_t;

    function automatic logic [3:0] cmd_for(input state_t s);
        logic [3:0] c;
        c = '0;
        case (s)
            S_ADDR_C: c[CMD_GET_ADDR] = 1'b1;
            S_DATA_C: c[CMD_GET_DATA] = 1'b1;
            S_CNT_C:  c[CMD_COUNT]    = 1'b1;
            S_WR_C:   c[CMD_WRITE]    = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_cmd_state(input state_t s);
        return (s == S_ADDR_C) || (s == S_DATA_C) || (s == S_CNT_C) || (s == S_WR_C);
    endfunction

endpackage

// File: rtl/conv_sequencer_ack.sv
// ack_timer: counts cycles spent waiting for a datapath acknowledge and
// flags when the allowed number of wait cycles has been used up.
module ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] r_count;

    // Count holds at the last wait cycle; the FSM leaves the wait state there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/conv_sequencer.sv
// Tile sequencer: walks num_tiles 4x4 tiles through the datapath handshake
// (address, data, count, write) and drives the SRAM addresses for each tile.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_tiles,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] wt_addr_cfg,
    input  logic [ADDR_W-1:0] out_base,
    output logic [3:0]        dp_cmd,
    input  logic [3:0]        dp_status,
    output logic [ADDR_W-1:0] input_address,
    output logic [ADDR_W-1:0] weight_address,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_num_tiles, r_in_base, r_out_base, r_tile, w_tile_inc;
    logic [ADDR_W-1:0] r_input_address, r_weight_address, r_write_address;
    logic [3:0]        r_dp_cmd, w_cmd;
    logic              r_write_en, r_busy, r_done, r_error;
    logic              w_write_en, w_busy, w_done, w_timeout;
    logic              w_expired, w_in_wait, w_ack, w_launch, w_zero_job, w_clear;

    assign w_tile_inc = r_tile + ADDR_W'(1);
    assign w_launch   = (r_state == S_IDLE) && start && (num_tiles != '0);
    assign w_zero_job = (r_state == S_IDLE) && start && (num_tiles == '0);
    assign w_clear    = is_cmd_state(r_state);

    ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Each wait state only listens to its own status bit.
    always_comb begin
        w_next    = r_state;
        w_in_wait = 1'b0;
        w_ack     = 1'b0;
        case (r_state)
            S_IDLE:   if (w_launch) w_next = S_ADDR_C;
            S_ADDR_C: w_next = S_ADDR_W;
            S_ADDR_W: begin
                w_in_wait = 1'b1;
                w_ack     = dp_status[ST_READY];
                if (w_ack)          w_next = S_DATA_C;
                else if (w_expired) w_next = S_IDLE;
            end
            S_DATA_C: w_next = S_DATA_W;
            S_DATA_W: begin
                w_in_wait = 1'b1;
                w_ack     = dp_status[ST_GOT_DATA];
                if (w_ack)          w_next = S_CNT_C;
                else if (w_expired) w_next = S_IDLE;
            end
            S_CNT_C:  w_next = S_CNT_W;
            S_CNT_W: begin
                w_in_wait = 1'b1;
                w_ack     = dp_status[ST_CNT_DONE];
                if (w_ack)          w_next = S_WR_C;
                else if (w_expired) w_next = S_IDLE;
            end
            S_WR_C:   w_next = S_WR_W;
            S_WR_W: begin
                w_in_wait = 1'b1;
                w_ack     = dp_status[ST_WRITTEN];
                if (w_ack)          w_next = S_NEXT;
                else if (w_expired) w_next = S_IDLE;
            end
            S_NEXT:   w_next = (w_tile_inc == r_num_tiles) ? S_FIN : S_ADDR_C;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        w_cmd      = cmd_for(w_next);
        w_busy     = (w_next != S_IDLE);
        w_done     = (w_next == S_FIN) || w_zero_job;
        w_write_en = (w_next == S_NEXT);
        w_timeout  = w_in_wait && !w_ack && w_expired;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dp_cmd         <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_write_en       <= 1'b0;
            r_error          <= 1'b0;
            r_num_tiles      <= '0;
            r_in_base        <= '0;
            r_out_base       <= '0;
            r_tile           <= '0;
            r_input_address  <= '0;
            r_weight_address <= '0;
            r_write_address  <= '0;
        end else begin
            r_dp_cmd   <= w_cmd;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_write_en <= w_write_en;
            if (w_launch) begin
                r_num_tiles      <= num_tiles;
                r_in_base        <= in_base;
                r_out_base       <= out_base;
                r_tile           <= '0;
                r_error          <= 1'b0;
                r_input_address  <= in_base;
                r_weight_address <= wt_addr_cfg;
                r_write_address  <= out_base;
            end else begin
                if (w_timeout) r_error <= 1'b1;
                // Addresses move only when the next tile starts, so they stay
                // valid through the write strobe in NEXT.
                if (r_state == S_NEXT) begin
                    r_tile <= w_tile_inc;
                    if (w_next == S_ADDR_C) begin
                        r_input_address <= r_in_base + w_tile_inc;
                        r_write_address <= r_out_base + w_tile_inc;
                    end
                end
            end
        end
    end

    assign dp_cmd         = r_dp_cmd;
    assign busy           = r_busy;
    assign done           = r_done;
    assign write_en       = r_write_en;
    assign error          = r_error;
    assign input_address  = r_input_address;
    assign weight_address = r_weight_address;
    assign write_address  = r_write_address;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: a timeline model of each job built from the
// handshake delays, compared against the DUT every cycle.
module tb_conv_sequencer;

    localparam int AW = 12;
    localparam int TO = 15;
    localparam int N  = 8192;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] num_tiles, in_base, wt_addr_cfg, out_base;
    logic [3:0]    dp_cmd;
    logic [3:0]    dp_status = 4'b0;
    logic [AW-1:0] input_address, weight_address, write_address;
    logic          write_en, busy, done, error;

    conv_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_tiles      (num_tiles),
        .in_base        (in_base),
        .wt_addr_cfg    (wt_addr_cfg),
        .out_base       (out_base),
        .dp_cmd         (dp_cmd),
        .dp_status      (dp_status),
        .input_address  (input_address),
        .weight_address (weight_address),
        .write_address  (write_address),
        .write_en       (write_en),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Expected output timeline, indexed by cycle number.
    logic [3:0]    e_cmd [N];
    bit            e_busy[N], e_done[N], e_we[N], e_err[N];
    logic [AW-1:0] e_ia[N], e_wt[N], e_wa[N];
    bit            model_on = 1'b0;

    // Acknowledge delay per tile and command (0 = never answer).
    int dly [0:15][0:3];
    int dq[$];
    int pend_bit = -1;
    int pend_cnt = 0;
    int pend_d   = 0;

    function automatic void set_exp(int c, logic [3:0] cmd, bit b, bit d, bit we, bit er,
                                    logic [AW-1:0] ia, logic [AW-1:0] wt, logic [AW-1:0] wa);
        if (c >= 0 && c < N) begin
            e_cmd[c] = cmd; e_busy[c] = b; e_done[c] = d; e_we[c] = we; e_err[c] = er;
            e_ia[c] = ia; e_wt[c] = wt; e_wa[c] = wa;
        end
    endfunction

    function automatic void fill_reset(int c0);
        for (int c = c0; c < N; c++) set_exp(c, 4'b0, 0, 0, 0, 0, '0, '0, '0);
    endfunction

    function automatic void plan_zero(int L);
        for (int c = L; c < N; c++)
            set_exp(c, 4'b0, 0, (c == L), 0, e_err[L-1], e_ia[L-1], e_wt[L-1], e_wa[L-1]);
    endfunction

    // Lays out the whole job: per tile, each command takes one cycle followed
    // by as many wait cycles as the acknowledge delay (or TO on a timeout).
    function automatic int plan(int L, int nt, logic [AW-1:0] ib, logic [AW-1:0] wt, logic [AW-1:0] ob);
        int t, w;
        bit ok, er;
        logic [AW-1:0] ia, wa;
        t = L; ok = 1; er = 0; ia = ib; wa = ob;
        dq.delete();
        pend_bit = -1;
        for (int k = 0; k < nt && ok; k++) begin
            ia = ib + AW'(k);
            wa = ob + AW'(k);
            for (int c = 0; c < 4 && ok; c++) begin
                set_exp(t, 4'b1000 >> c, 1, 0, 0, 0, ia, wt, wa); t++;
                dq.push_back(dly[k][c]);
                w = (dly[k][c] == 0) ? TO : dly[k][c];
                for (int j = 0; j < w; j++) begin set_exp(t, 4'b0, 1, 0, 0, 0, ia, wt, wa); t++; end
                if (dly[k][c] == 0) begin ok = 0; er = 1; end
            end
            if (ok) begin set_exp(t, 4'b0, 1, 0, 1, 0, ia, wt, wa); t++; end
        end
        if (ok) begin set_exp(t, 4'b0, 1, 1, 0, 0, ia, wt, wa); t++; end
        for (int c = t; c < N; c++) set_exp(c, 4'b0, 0, 0, 0, er, ia, wt, wa);
        return t;
    endfunction

    // Datapath responder: random noise on unrelated status bits, the matching
    // bit raised exactly dly cycles after its command.
    logic [3:0] rs;
    always @(negedge clk) begin
        rs = 4'($urandom);
        if (pend_bit >= 0) pend_cnt++;
        if (dp_cmd != 4'b0) begin
            case (dp_cmd)
                4'b1000: pend_bit = 2;
                4'b0100: pend_bit = 3;
                4'b0010: pend_bit = 1;
                default: pend_bit = 0;
            endcase
            pend_cnt = 0;
            pend_d   = (dq.size() > 0) ? dq.pop_front() : 1;
        end
        if (pend_bit >= 0) begin
            rs[pend_bit] = 1'b0;
            if (pend_d != 0 && pend_cnt == pend_d) begin
                rs[pend_bit] = 1'b1;
                pend_bit = -1;
            end
        end
        dp_status = rs;
    end

    logic [3:0] prev_cmd = 4'b0;
    always @(negedge clk) begin
        if (model_on && cyc < N) begin
            vectors++;
            if ({dp_cmd, busy, done, write_en, error, input_address, weight_address, write_address} !==
                {e_cmd[cyc], e_busy[cyc], e_done[cyc], e_we[cyc], e_err[cyc], e_ia[cyc], e_wt[cyc], e_wa[cyc]}) begin
                miscompares++;
                $display("FAIL cycle %0d: got cmd %b busy %b done %b we %b err %b ia %h wt %h wa %h, need cmd %b busy %b done %b we %b err %b ia %h wt %h wa %h",
                         cyc, dp_cmd, busy, done, write_en, error, input_address, weight_address, write_address,
                         e_cmd[cyc], e_busy[cyc], e_done[cyc], e_we[cyc], e_err[cyc], e_ia[cyc], e_wt[cyc], e_wa[cyc]);
            end
            vectors++;
            assert ($onehot0(dp_cmd) && !((|dp_cmd) && (|prev_cmd))) else begin
                miscompares++;
                $display("FAIL cmd_protocol cycle %0d: cmd %b after %b, need one-hot/zero and no back-to-back", cyc, dp_cmd, prev_cmd);
            end
            prev_cmd = dp_cmd;
        end
    end

    logic [AW-1:0] q_ia[$], q_wa[$];
    int n_done = 0, n_busy = 0, n_cmd = 0;
    always @(negedge clk) begin
        if (write_en) q_wa.push_back(write_address);
        if (dp_cmd == 4'b1000) q_ia.push_back(input_address);
        if (done) n_done++;
        if (busy) n_busy++;
        if (|dp_cmd) n_cmd++;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qia(int i);
        return (q_ia.size() > i) ? int'(q_ia[i]) : -1;
    endfunction

    function automatic int qwa(int i);
        return (q_wa.size() > i) ? int'(q_wa[i]) : -1;
    endfunction

    task automatic set_dly(input int d);
        for (int k = 0; k < 16; k++) for (int c = 0; c < 4; c++) dly[k][c] = d;
    endtask

    // Called at a negedge with the DUT idle; start is sampled at the next edge.
    task automatic start_job(input int nt, input logic [AW-1:0] ib, input logic [AW-1:0] wt,
                             input logic [AW-1:0] ob, output int L, output int t_end);
        num_tiles = AW'(nt); in_base = ib; wt_addr_cfg = wt; out_base = ob; start = 1'b1;
        q_ia.delete(); q_wa.delete(); n_done = 0; n_busy = 0; n_cmd = 0;
        L = cyc + 1;
        if (nt == 0) begin plan_zero(L); t_end = L + 1; end
        else t_end = plan(L, nt, ib, wt, ob);
        @(negedge clk);
        num_tiles = AW'($urandom); in_base = AW'($urandom);
        wt_addr_cfg = AW'($urandom); out_base = AW'($urandom);
        start = (nt != 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int t_end);
        while (cyc < t_end + 2) @(negedge clk);
    endtask

    int L, t_end, nt;

    initial begin
        reset = 1'b1; start = 1'b0;
        num_tiles = '0; in_base = '0; wt_addr_cfg = '0; out_base = '0;
        set_dly(1);
        fill_reset(0);
        model_on = 1'b1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cmd", int'(dp_cmd), 0);
        chk("reset_error", int'(error), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Three tiles, immediate acknowledges.
        start_job(3, 12'h010, 12'h040, 12'h200, L, t_end);
        wait_end(t_end);
        chk("basic_ia0", qia(0), 'h010); chk("basic_ia1", qia(1), 'h011); chk("basic_ia2", qia(2), 'h012);
        chk("basic_wa0", qwa(0), 'h200); chk("basic_wa1", qwa(1), 'h201); chk("basic_wa2", qwa(2), 'h202);
        chk("basic_we_count", q_wa.size(), 3);
        chk("basic_done_count", n_done, 1);
        chk("basic_busy_cycles", n_busy, 28);
        chk("basic_weight_addr", int'(weight_address), 'h040);

        // got_data arrives 4 cycles after get_data.
        for (int k = 0; k < 3; k++) dly[k][1] = 4;
        start_job(3, 12'h010, 12'h040, 12'h200, L, t_end);
        wait_end(t_end);
        chk("slow_busy_cycles", n_busy, 37);
        chk("slow_error", int'(error), 0);
        chk("slow_done_count", n_done, 1);

        // count_done never arrives.
        set_dly(1);
        dly[0][2] = 0;
        start_job(2, 12'h100, 12'h040, 12'h300, L, t_end);
        wait_end(t_end);
        chk("timeout_error", int'(error), 1);
        chk("timeout_done_count", n_done, 0);
        chk("timeout_we_count", q_wa.size(), 0);
        chk("timeout_busy_cycles", n_busy, 20);

        // Zero-tile job.
        set_dly(1);
        start_job(0, 12'h123, 12'h456, 12'h789, L, t_end);
        wait_end(t_end);
        chk("zero_done_count", n_done, 1);
        chk("zero_cmd_cycles", n_cmd, 0);
        chk("zero_busy_cycles", n_busy, 0);

        // Input address wraps past the top of the address space.
        start_job(2, 12'hFFF, 12'h040, 12'h7FE, L, t_end);
        wait_end(t_end);
        chk("wrap_ia0", qia(0), 'hFFF);
        chk("wrap_ia1", qia(1), 'h000);
        chk("wrap_error_cleared", int'(error), 0);

        // Reset during WR_W of tile 1, then a fresh job.
        dly[1][3] = 6;
        start_job(3, 12'h020, 12'h050, 12'h400, L, t_end);
        while (cyc < L + 16) @(negedge clk);
        #1 reset = 1'b1;
        fill_reset(cyc + 1);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_cmd", int'(dp_cmd), 0);
        chk("abort_ia", int'(input_address), 0);
        chk("abort_wa", int'(write_address), 0);
        chk("abort_wt", int'(weight_address), 0);
        chk("abort_we_count", q_wa.size(), 1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        set_dly(1);
        start_job(3, 12'h020, 12'h050, 12'h400, L, t_end);
        wait_end(t_end);
        chk("restart_ia0", qia(0), 'h020);
        chk("restart_done_count", n_done, 1);

        // Randomized jobs with random acknowledge delays and timeouts.
        for (int j = 0; j < 15; j++) begin
            if (cyc > N - 600) break;
            nt = $urandom_range(0, 4);
            for (int k = 0; k < 16; k++) for (int c = 0; c < 4; c++) begin
                int r;
                r = $urandom_range(0, 99);
                dly[k][c] = (r < 4) ? 0 : ((r < 12) ? $urandom_range(7, TO) : $urandom_range(1, 3));
            end
            start_job(nt, AW'($urandom), AW'($urandom), AW'($urandom), L, t_end);
            wait_end(t_end);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        model_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(N * 10 + 1000);
        $display("FAIL watchdog: simulation did not finish within %0d cycles", N);
        $fatal(1, "watchdog");
    end

endmodule
